mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the processor's single unified memory port between the IF stage (instruction fetch) and the MEM stage (data load/store). One transaction is in flight at a time. Grants go to data over fetch, with an optional anti-starvation guard for fetch. Owner and payload are registered at arbitration, the request is held to memory until accepted, and read data is routed back to the owning stage.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive IF losses before IF is forced to win (guard builds only)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch accepted by memory
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- dm_req  in  1  data request; held with payload until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  byte enables
- dm_gnt  out  1  one-cycle pulse: data request accepted
- dm_rvalid  out  1  one-cycle pulse: load data valid
- dm_rdata  out  DATA_W  load data
- mem_req, mem_we, mem_addr, mem_wdata, mem_be  out  1/1/ADDR_W/DATA_W/DATA_W/8  registered request to memory
- mem_ready  in  1  memory accepts when mem_req & mem_ready
- mem_rvalid  in  1  read data valid, one or more cycles after accept
- mem_rdata  in  DATA_W  read data

## Operation
- FSM has three states:
  - IDLE: arbitrate. The winner's payload and owner are latched and the FSM goes to ISSUE. With no request, it stays in IDLE.
  - ISSUE: mem_req=1 with the latched payload. On mem_ready, the owner's gnt pulses. A store then returns to IDLE; a load goes to WAIT_R.
  - WAIT_R: on mem_rvalid, mem_rdata is copied to the owner's rdata, the owner's rvalid pulses, and the FSM goes to IDLE.
- Priority: dm_req beats if_req when both are asserted in IDLE.
- Payload is sampled only at arbitration. Input changes after that are ignored until the next IDLE decision.
- Dropping a req before its gnt is a protocol violation. The latched transaction still completes.
- mem_rvalid in IDLE or ISSUE is ignored and must not produce any rvalid.
- if_rdata and dm_rdata hold their last value between pulses.
- Reset (asynchronous, active-low):
  - state=IDLE; all gnt, rvalid and mem_* outputs are 0; rdata is 0; the starve counter is 0.
  - Reset mid-transaction abandons it. A late mem_rvalid after reset is ignored.

## Timing
- Request seen in IDLE at edge N: mem_req=1 from cycle N+1.
- Acceptance:
  - With mem_ready=1 in cycle N+1, gnt pulses in N+1.
  - Each cycle of mem_ready=0 delays gnt by one.
- Load return: rvalid appears in the same cycle as mem_rvalid (combinational route from the registered owner), earliest N+2.
- Back-to-back:
  - A store completes IDLE→ISSUE→IDLE, giving at most one transaction every 2 cycles.
  - A load takes at least 3 cycles.
- Arbitration happens only in IDLE. A request arriving during ISSUE/WAIT_R waits.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined:
  - A counter, saturating at STARVE_LIMIT, increments on each IDLE decision where if_req=1 loses to dm_req.
  - When the count equals STARVE_LIMIT, the next IDLE decision with if_req=1 grants IF regardless of dm_req.
  - The counter clears when IF wins arbitration.
- Undefined: strict data priority, and no counter logic exists.

## Structure
- Shared package riscv_mem_pkg holds:
  - typedef enum arb_state_e {IDLE, ISSUE, WAIT_R}
  - typedef enum arb_owner_e {OWN_IF, OWN_DM}
  - default width constants
- No sub-module is needed. The FSM, payload register and optional counter stay in one module.

## Test plan
- Fetch only: if_req, if_addr=0x100, mem_ready=1, mem_rvalid 1 cycle after accept with 0x00000013 → if_gnt at N+1, if_rvalid with if_rdata=0x00000013 at N+2.
- Contention: if_req and dm_req (load 0x2000) both at N → dm_gnt first, dm_rdata returned, then IF issued from the next IDLE; no if_gnt before dm_rvalid.
- Store with backpressure: dm_we=1, addr 0x3000, wdata 0xDEADBEEF, be=4'b0011, mem_ready low 3 cycles → mem_* stable for 4 cycles, dm_gnt on the 4th, no dm_rvalid, back to IDLE.
- Stray/reset: reset=0 asserted in WAIT_R, then released, then mem_rvalid pulses → all outputs 0, no rvalid, state IDLE.
- Guard (macro defined, STARVE_LIMIT=4): dm_req continuously with back-to-back stores, if_req held → IF granted on the 5th arbitration.
- Guard (macro undefined): same stimulus → IF never granted while dm_req is high.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
// Used by mem_port_arbiter.
package riscv_mem_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and data (MEM); data has priority.
// Define MEM_ARB_STARVE_GUARD_EN to force IF through after STARVE_LIMIT losses.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    arb_state_e           state_q, state_d;
    arb_owner_e           owner_q, owner_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W/8-1:0]  be_q, be_d;
    logic [DATA_W-1:0]    if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]    dm_rdata_q, dm_rdata_d;

    logic any_req;
    logic pick_dm;
    logic issue;
    logic rd_ret;

    assign any_req = if_req | dm_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             force_if;

    assign force_if = if_req && (cnt_q == CNT_W'(STARVE_LIMIT));
    assign pick_dm  = dm_req && !force_if;

    // Count only decisions where IF was actually waiting and lost.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && if_req) begin
            if (!pick_dm) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign pick_dm = dm_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_d = we_q ? IDLE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue     = (state_q == ISSUE);
        rd_ret    = (state_q == WAIT_R) && mem_rvalid;
        mem_req   = issue;
        mem_we    = issue && we_q;
        mem_addr  = issue ? addr_q : '0;
        mem_wdata = issue ? wdata_q : '0;
        mem_be    = issue ? be_q : '0;
        if_gnt    = issue && mem_ready && (owner_q == OWN_IF);
        dm_gnt    = issue && mem_ready && (owner_q == OWN_DM);
        if_rvalid = rd_ret && (owner_q == OWN_IF);
        dm_rvalid = rd_ret && (owner_q == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;
    end

    // Payload is captured only on the IDLE decision.
    always_comb begin
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata;
        dm_rdata_d = dm_rdata;
        if (state_q == IDLE && any_req) begin
            owner_d = pick_dm ? OWN_DM : OWN_IF;
            we_d    = pick_dm && dm_we;
            addr_d  = pick_dm ? dm_addr : if_addr;
            wdata_d = pick_dm ? dm_wdata : '0;
            be_d    = pick_dm ? dm_be : '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction record.
    bit        m_busy = 0, m_acc = 0, m_own_dm = 0, m_we = 0;
    bit [31:0] m_addr = 0, m_wdata = 0, m_if_last = 0, m_dm_last = 0;
    bit [3:0]  m_be = 0;
    int        m_cnt = 0;
    logic      take_dm;

    assign take_dm = dm_req && !(GUARD && if_req && m_cnt >= LIMIT);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_acc <= 0; m_own_dm <= 0; m_we <= 0;
            m_addr <= 0; m_wdata <= 0; m_be <= 0;
            m_if_last <= 0; m_dm_last <= 0; m_cnt <= 0;
        end else if (!m_busy) begin
            if (dm_req || if_req) begin
                m_busy   <= 1;
                m_acc    <= 0;
                m_own_dm <= take_dm;
                m_we     <= take_dm && dm_we;
                m_addr   <= take_dm ? dm_addr : if_addr;
                m_wdata  <= take_dm ? dm_wdata : 32'h0;
                m_be     <= take_dm ? dm_be : 4'hf;
                if (!take_dm)
                    m_cnt <= 0;
                else if (if_req)
                    m_cnt <= (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
            end
        end else if (!m_acc) begin
            if (mem_ready) begin
                if (m_we) m_busy <= 0;
                else m_acc <= 1;
            end
        end else if (mem_rvalid) begin
            m_busy <= 0;
            if (m_own_dm) m_dm_last <= mem_rdata;
            else m_if_last <= mem_rdata;
        end
    end

    logic [137:0] dut_vec;
    assign dut_vec = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid,
                      dm_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be};

    task automatic chk(input string nm, input logic [137:0] got,
                       input logic [137:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            bit        iss, ret, ig, dg, ir, dr;
            bit [31:0] ird, drd;
            iss = m_busy && !m_acc;
            ret = m_busy && m_acc && mem_rvalid && reset;
            if (!reset) iss = 0;
            ig  = iss && mem_ready && !m_own_dm;
            dg  = iss && mem_ready && m_own_dm;
            ir  = ret && !m_own_dm;
            dr  = ret && m_own_dm;
            ird = ir ? mem_rdata : m_if_last;
            drd = dr ? mem_rdata : m_dm_last;
            chk("model_cycle", dut_vec,
                {ig, ir, ird, dg, dr, drd, iss, iss && m_we,
                 iss ? m_addr : 32'h0, iss ? m_wdata : 32'h0,
                 iss ? m_be : 4'h0});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int gcount, if_at, if_late;
    bit rv;

    initial begin
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        tick();
        tick();
        #1 chk("reset_outputs", dut_vec, '0);
        @(negedge clk) reset = 1'b1;
        tick();

        // Fetch only
        if_req = 1; if_addr = 32'h100; mem_ready = 1;
        @(negedge clk) chk("f_idle_noreq", mem_req, 0);
        tick();
        @(negedge clk);
        chk("f_gnt", {if_gnt, mem_req, mem_we}, 3'b110);
        chk("f_addr", mem_addr, 32'h100);
        tick();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h13;
        @(negedge clk);
        chk("f_rvalid", {if_rvalid, dm_rvalid}, 2'b10);
        chk("f_rdata", if_rdata, 32'h13);
        tick();
        mem_rvalid = 0;
        @(negedge clk);
        chk("f_hold", {if_rvalid, if_rdata}, {1'b0, 32'h13});

        // Contention: load beats fetch
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_be = 4'hf;
        tick();
        @(negedge clk);
        chk("c_dm_first", {dm_gnt, if_gnt}, 2'b10);
        chk("c_addr", mem_addr, 32'h2000);
        tick();
        dm_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("c_dm_ret", {dm_rvalid, if_gnt, dm_rdata}, {2'b10, 32'hCAFEF00D});
        tick();
        mem_rvalid = 0;
        @(negedge clk) chk("c_idle", {if_gnt, mem_req}, 2'b00);
        tick();
        @(negedge clk);
        chk("c_if_gnt", {if_gnt, mem_addr}, {1'b1, 32'h104});
        tick();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h93;
        @(negedge clk);
        chk("c_if_ret", {if_rvalid, if_rdata, dm_rdata},
            {1'b1, 32'h93, 32'hCAFEF00D});
        tick();
        mem_rvalid = 0;

        // Store with backpressure; late payload changes ignored
        mem_ready = 0;
        dm_req = 1; dm_we = 1; dm_addr = 32'h3000;
        dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
        tick();
        dm_wdata = 32'h11111111; dm_addr = 32'h3FFC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s_stall", {dm_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_be},
                {3'b011, 32'h3000, 32'hDEADBEEF, 4'b0011});
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        chk("s_gnt", {dm_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_be},
            {3'b111, 32'h3000, 32'hDEADBEEF, 4'b0011});
        tick();
        dm_req = 0; mem_rvalid = 1; mem_rdata = 32'h99;
        @(negedge clk);
        chk("s_stray", {dm_rvalid, if_rvalid, mem_req, dm_rdata},
            {3'b000, 32'hCAFEF00D});
        tick();
        mem_rvalid = 0;

        // Reset while waiting for load data
        dm_req = 1; dm_we = 0; dm_addr = 32'h4000; dm_be = 4'hf;
        tick();
        @(negedge clk) chk("r_gnt", dm_gnt, 1);
        tick();
        dm_req = 0;
        reset = 0;
        #1 chk("r_async", dut_vec, '0);
        @(negedge clk) reset = 1;
        tick();
        mem_rvalid = 1; mem_rdata = 32'h55555555;
        @(negedge clk) chk("r_late_rvalid", dut_vec, '0);
        tick();
        mem_rvalid = 0;
        if_req = 1; if_addr = 32'h200;
        tick();
        @(negedge clk) chk("r_idle_gnt", {if_gnt, mem_addr}, {1'b1, 32'h200});
        tick();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        @(negedge clk) chk("r_if_ret", {if_rvalid, if_rdata}, {1'b1, 32'h77});
        tick();
        mem_rvalid = 0;

        // Starvation: back-to-back stores with fetch waiting
        dm_req = 1; dm_we = 1; dm_addr = 32'h5000;
        dm_wdata = 32'h1; dm_be = 4'hf;
        if_req = 1; if_addr = 32'h300;
        gcount = 0; if_at = 0; if_late = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            rv = 0;
            if (dm_gnt) gcount++;
            if (if_gnt) begin
                gcount++;
                if (if_at == 0) if_at = gcount;
                rv = 1;
            end
            tick();
            mem_rvalid = rv; mem_rdata = 32'h13;
            if (rv) if_req = 0;
        end
        chk("g_if_win_index", if_at, GUARD ? 5 : 0);
        dm_req = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rv = 0;
            if (if_gnt) begin
                if_late++;
                rv = 1;
            end
            tick();
            mem_rvalid = rv;
            if (rv) if_req = 0;
        end
        chk("g_if_after_dm", if_late, GUARD ? 0 : 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
